async_tx: RTL and testbench

ASYNC_TX -- requirements
Module: async_tx

---
 rtl/async_tx.sv | 91 +++++++++
 tb/tb_async_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/async_tx.sv
// rtl/async_tx.sv - coalescing single-entry sample writer into a FIFO write port.
// Newer samples overwrite an unwritten pending one; a GAP cycle follows every write.
module async_tx #(
   parameter int WIDTH     = 12,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 full,
   output logic                 w_en,
   output logic [WIDTH-1:0]     data,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] coalesce_cnt
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      PEND  = 4'b0010,
      WRITE = 4'b0100,
      GAP   = 4'b1000
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     pending_q, pending_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 launch;

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      launch       = 1'b0;

      case (state_q)
         IDLE:    if (wr_valid) state_d = PEND;
         PEND: begin
            if (!full) begin
               state_d = WRITE;
               launch  = 1'b1;
            end
         end
         WRITE:   state_d = GAP;
         GAP:     state_d = (pend_valid_q || wr_valid) ? PEND : IDLE;
         default: state_d = IDLE;
      endcase

      // A strobe coinciding with the launch bypasses the pending register entirely.
      if (launch) begin
         data_d       = wr_valid ? wr_data : pending_q;
         pend_valid_d = 1'b0;
      end else if (wr_valid) begin
         pending_d    = wr_data;
         pend_valid_d = 1'b1;
      end

      if (wr_valid && pend_valid_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         data_q       <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
      end
   end

   // Decoded straight from the state flop so an asynchronous reset drops it at once.
   assign w_en         = (state_q == WRITE);
   assign busy         = (state_q != IDLE) || pend_valid_q;
   assign data         = data_q;
   assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_async_tx.sv
// tb/tb_async_tx.sv - directed and random stimulus against a timing-rule model of async_tx.
module tb_async_tx;
   localparam int W       = 12;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          full = 1'b0;
   logic          w_en;
   logic [W-1:0]  data;
   logic          busy;
   logic [CW-1:0] coalesce_cnt;

   int tests = 0;
   int fails = 0;
   int writes = 0;

   // Model: a write fires when a sample is held, at least 2 cycles after the previous write, and full=0.
   bit         m_pv;
   logic [W-1:0] m_pend, m_data;
   int         m_cnt;
   int         cyc = 0;
   int         m_lw = -100;

   always #5 clk = ~clk;

   async_tx #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .full(full),
      .w_en(w_en), .data(data), .busy(busy), .coalesce_cnt(coalesce_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pv = 1'b0; m_pend = '0; m_data = '0; m_cnt = 0; m_lw = cyc - 100;
   endtask

   task automatic check_outputs();
      chk($sformatf("w_en@%0d", cyc), {31'b0, w_en}, {31'b0, (m_lw == cyc)});
      chk($sformatf("data@%0d", cyc), {20'b0, data}, {20'b0, m_data});
      chk($sformatf("busy@%0d", cyc), {31'b0, busy}, {31'b0, (m_pv || cyc <= m_lw + 1)});
      chk($sformatf("cnt@%0d", cyc), {24'b0, coalesce_cnt}, m_cnt);
      if (w_en === 1'b1) writes++;
   endtask

   task automatic model_advance(input bit v, input logic [W-1:0] d, input bit f);
      bit fire;
      fire = m_pv && (cyc >= m_lw + 2) && !f;
      if (v && m_pv && m_cnt < CNT_MAX) m_cnt++;
      if (fire) begin
         m_data = v ? d : m_pend;
         m_pv   = 1'b0;
         m_lw   = cyc + 1;
      end else if (v) begin
         m_pend = d;
         m_pv   = 1'b1;
      end
      cyc++;
   endtask

   task automatic step(input bit v, input logic [W-1:0] d, input bit f);
      @(negedge clk);
      wr_valid = v; wr_data = d; full = f;
      #1;
      check_outputs();
      model_advance(v, d, f);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      wr_valid = 1'b0; full = 1'b0; rst_n = 1'b0;
      #1;
      chk({tag, "_rst_wen"}, {31'b0, w_en}, 32'd0);
      chk({tag, "_rst_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_rst_data"}, {20'b0, data}, 32'd0);
      chk({tag, "_rst_cnt"}, {24'b0, coalesce_cnt}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      writes = 0;
   endtask

   initial begin
      logic [W-1:0] rd;
      bit rv, rf;

      // Single sample: w_en only at cycle 2, idle again from cycle 4.
      do_reset("init");
      step(1'b1, 12'h5A3, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         step(1'b0, '0, 1'b0);
         chk($sformatf("single_wen_c%0d", c), {31'b0, w_en}, {31'b0, (c == 2)});
         chk($sformatf("single_busy_c%0d", c), {31'b0, busy}, {31'b0, (c < 4)});
      end
      chk("single_writes", writes, 32'd1);
      chk("single_data", {20'b0, data}, 32'h5A3);

      // Blocked write with coalescing under full.
      do_reset("blocked");
      for (int c = 0; c < 10; c++) begin
         if (c == 0)      step(1'b1, 12'h100, 1'b1);
         else if (c == 3) step(1'b1, 12'h200, 1'b1);
         else if (c == 5) step(1'b1, 12'h300, 1'b1);
         else             step(1'b0, '0, 1'b1);
      end
      for (int c = 10; c < 16; c++) step(1'b0, '0, 1'b0);
      chk("blocked_writes", writes, 32'd1);
      chk("blocked_data", {20'b0, data}, 32'h300);
      chk("blocked_cnt", {24'b0, coalesce_cnt}, 32'd2);

      // Bypass: full falls together with a new strobe.
      do_reset("bypass");
      step(1'b1, 12'h111, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b1, 12'h222, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("bypass_wen", {31'b0, w_en}, 32'd1);
      chk("bypass_data", {20'b0, data}, 32'h222);
      chk("bypass_cnt", {24'b0, coalesce_cnt}, 32'd1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("bypass_idle_busy", {31'b0, busy}, 32'd0);

      // Back-to-back strobes one cycle apart coalesce into a single write.
      do_reset("b2b1");
      step(1'b1, 12'h001, 1'b0);
      step(1'b1, 12'h002, 1'b0);
      for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b0);
      chk("b2b1_writes", writes, 32'd1);
      chk("b2b1_data", {20'b0, data}, 32'h002);
      chk("b2b1_cnt", {24'b0, coalesce_cnt}, 32'd1);

      // Strobes three cycles apart give two writes.
      do_reset("b2b3");
      step(1'b1, 12'h001, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b1, 12'h002, 1'b0);
      for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0);
      chk("b2b3_writes", writes, 32'd2);
      chk("b2b3_data", {20'b0, data}, 32'h002);
      chk("b2b3_cnt", {24'b0, coalesce_cnt}, 32'd0);

      // Saturation, then reset asserted during WRITE.
      do_reset("sat");
      for (int i = 0; i < 300; i++) step(1'b1, W'($urandom), 1'b1);
      chk("sat_cnt", {24'b0, coalesce_cnt}, 32'd255);
      step(1'b0, '0, 1'b0);
      @(posedge clk);
      #1;
      chk("sat_pre_rst_wen", {31'b0, w_en}, 32'd1);
      wr_valid = 1'b1; wr_data = 12'hABC;
      rst_n = 1'b0;
      #1;
      chk("midrst_wen", {31'b0, w_en}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_cnt", {24'b0, coalesce_cnt}, 32'd0);
      wr_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      writes = 0;
      for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0);
      chk("midrst_no_write", writes, 32'd0);

      // Random traffic against the model.
      do_reset("rand");
      for (int i = 0; i < 600; i++) begin
         rv = ($urandom_range(0, 2) == 0);
         rf = ($urandom_range(0, 3) == 0);
         rd = W'($urandom);
         step(rv, rd, rf);
      end
      for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
